// File: rtl/sgd_pkg.sv
// rtl/sgd_pkg.sv - shared constants, state type and word-count helper for the model write-back path
package sgd_pkg;
  localparam int NUM_BITS_PER_BANK = 8;
  localparam int DIS_X_BIT_DEPTH   = 10;
  localparam int BIT_WIDTH_OF_BANK = 4;
  localparam int ENGINE_NUM_WIDTH  = 3;
  localparam int WORD_SHIFT        = BIT_WIDTH_OF_BANK + ENGINE_NUM_WIDTH;
  localparam int HOST_LINE_W       = 512;
  localparam int HOST_LINE_BYTES   = 64;
  localparam int X_RD_LATENCY      = 2;
  localparam int FIFO_DEPTH        = 4;
  localparam int WORD_CREDITS      = 2 * FIFO_DEPTH;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} wr_state_t;

  // Number of model BRAM words covering `dim` features (partial word rounds up).
  function automatic logic [31:0] word_count(input logic [31:0] dim);
    logic [31:0] hi;
    logic [31:0] lo;
    hi = dim >> WORD_SHIFT;
    lo = dim & ((32'd1 << WORD_SHIFT) - 32'd1);
    return hi + 32'(lo != 32'd0);
  endfunction
endpackage

// File: rtl/sgd_x_host_wr_fifo.sv
// rtl/sgd_x_host_wr_fifo.sv - 4-entry host-line FIFO with occupancy count
module sgd_x_host_wr_fifo
  import sgd_pkg::*;
#(
  parameter int W = HOST_LINE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [2:0]   count
);
  logic [W-1:0] mem [FIFO_DEPTH];
  logic [1:0]   wr_ptr;
  logic [1:0]   rd_ptr;

  assign dout = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/sgd_x_host_wr.sv
// rtl/sgd_x_host_wr.sv - streams the model BRAM to host memory as 64-byte lines
// Optional: SGD_X_HOST_WR_EPOCH_OFFSET_EN keeps each epoch's model at its own offset.
module sgd_x_host_wr
  import sgd_pkg::*;
#(
  parameter int X_DATA_W = NUM_BITS_PER_BANK * 32,
  parameter int X_ADDR_W = DIS_X_BIT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   started,
  input  logic [31:0]            dimension,
  input  logic [63:0]            addr_model,
  input  logic                   writing_x_to_host_memory_en,
  output logic                   writing_x_to_host_memory_done,
  output logic                   x_rd_en,
  output logic [X_ADDR_W-1:0]    x_rd_addr,
  input  logic [X_DATA_W-1:0]    x_rd_data,
  output logic                   um_tx_wr_valid,
  output logic [63:0]            um_tx_wr_addr,
  output logic [HOST_LINE_W-1:0] um_tx_wr_data,
  input  logic                   um_tx_wr_ready,
  output logic [31:0]            x_host_wr_lines
);
  wr_state_t               state;
  logic [31:0]             n_q, n_lat, l_lat, l_new;
  logic [31:0]             rd_idx, wr_idx, acc_cnt;
  logic [63:0]             base_eff, epoch_off;
  logic                    rd_v1, rd_v2;
  logic                    half_vld;
  logic [X_DATA_W-1:0]     half_q;
  logic                    push;
  logic [HOST_LINE_W-1:0]  push_data;
  logic [2:0]              fifo_count;
  logic [3:0]              words_held;
  logic                    can_read, accept, start;

  assign start  = (state == ST_IDLE) && writing_x_to_host_memory_en;
  assign accept = um_tx_wr_valid && um_tx_wr_ready;
  assign l_new  = (n_q + 32'd1) >> 1;

  // Every word already committed to the pipeline owns a FIFO half-slot.
  assign words_held = {fifo_count, 1'b0} + 4'(x_rd_en) + 4'(rd_v1) + 4'(rd_v2) + 4'(half_vld);
  assign can_read   = words_held < 4'(WORD_CREDITS);

`ifdef SGD_X_HOST_WR_EPOCH_OFFSET_EN
  logic [31:0] epoch;
  logic        started_q;

  assign epoch_off = (64'(epoch) * 64'(l_new)) << 6;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      epoch     <= '0;
      started_q <= 1'b0;
    end else begin
      started_q <= started;
      if (started && !started_q)
        epoch <= '0;
      else if (state == ST_DONE && !writing_x_to_host_memory_en)
        epoch <= epoch + 32'd1;
    end
  end
`else
  logic unused_started;
  assign unused_started = started;
  assign epoch_off      = '0;
`endif

  assign um_tx_wr_valid = (fifo_count != 3'd0);
  assign um_tx_wr_addr  = base_eff + (64'(acc_cnt) << 6);

  always_comb begin
    push      = 1'b0;
    push_data = '0;
    if (rd_v2) begin
      if (half_vld) begin
        push      = 1'b1;
        push_data = {x_rd_data, half_q};
      end else if (wr_idx == n_lat - 32'd1) begin
        push      = 1'b1;
        push_data = {{X_DATA_W{1'b0}}, x_rd_data};
      end
    end
  end

  sgd_x_host_wr_fifo #(.W(HOST_LINE_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_data),
    .pop   (accept),
    .dout  (um_tx_wr_data),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_q             <= '0;
      rd_v1           <= 1'b0;
      rd_v2           <= 1'b0;
      half_vld        <= 1'b0;
      half_q          <= '0;
      wr_idx          <= '0;
      x_host_wr_lines <= '0;
    end else begin
      n_q   <= word_count(dimension);
      rd_v1 <= x_rd_en;
      rd_v2 <= rd_v1;
      if (accept) x_host_wr_lines <= x_host_wr_lines + 32'd1;
      if (start) begin
        wr_idx   <= '0;
        half_vld <= 1'b0;
      end else if (rd_v2) begin
        wr_idx <= wr_idx + 32'd1;
        if (half_vld) begin
          half_vld <= 1'b0;
        end else if (wr_idx != n_lat - 32'd1) begin
          half_vld <= 1'b1;
          half_q   <= x_rd_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                         <= ST_IDLE;
      writing_x_to_host_memory_done <= 1'b0;
      x_rd_en                       <= 1'b0;
      x_rd_addr                     <= '0;
      rd_idx                        <= '0;
      n_lat                         <= '0;
      l_lat                         <= '0;
      base_eff                      <= '0;
      acc_cnt                       <= '0;
    end else begin
      x_rd_en <= 1'b0;
      if (accept) acc_cnt <= acc_cnt + 32'd1;
      case (state)
        ST_IDLE: begin
          if (writing_x_to_host_memory_en) begin
            state    <= ST_ISSUE;
            n_lat    <= n_q;
            l_lat    <= l_new;
            base_eff <= addr_model + epoch_off;
            rd_idx   <= '0;
            acc_cnt  <= '0;
          end
        end
        ST_ISSUE: begin
          if (n_lat == 32'd0) begin
            state                         <= ST_DONE;
            writing_x_to_host_memory_done <= 1'b1;
          end else if (can_read) begin
            x_rd_en   <= 1'b1;
            x_rd_addr <= rd_idx[X_ADDR_W-1:0];
            rd_idx    <= rd_idx + 32'd1;
            if (rd_idx == n_lat - 32'd1) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (accept && acc_cnt == l_lat - 32'd1) begin
            state                         <= ST_DONE;
            writing_x_to_host_memory_done <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!writing_x_to_host_memory_en) begin
            state                         <= ST_IDLE;
            writing_x_to_host_memory_done <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sgd_x_host_wr.sv
// tb/tb_sgd_x_host_wr.sv - self-checking bench for sgd_x_host_wr
module tb_sgd_x_host_wr;
  localparam int XW = 256;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n, started, en, done;
  logic [31:0]   dimension;
  logic [63:0]   addr_model;
  logic          x_rd_en;
  logic [AW-1:0] x_rd_addr;
  logic [XW-1:0] x_rd_data;
  logic          valid, ready;
  logic [63:0]   wr_addr;
  logic [511:0]  wr_data;
  logic [31:0]   lines;

  sgd_x_host_wr #(.X_DATA_W(XW), .X_ADDR_W(AW)) dut (
    .clk                           (clk),
    .rst_n                         (rst_n),
    .started                       (started),
    .dimension                     (dimension),
    .addr_model                    (addr_model),
    .writing_x_to_host_memory_en   (en),
    .writing_x_to_host_memory_done (done),
    .x_rd_en                       (x_rd_en),
    .x_rd_addr                     (x_rd_addr),
    .x_rd_data                     (x_rd_data),
    .um_tx_wr_valid                (valid),
    .um_tx_wr_addr                 (wr_addr),
    .um_tx_wr_data                 (wr_data),
    .um_tx_wr_ready                (ready),
    .x_host_wr_lines               (lines)
  );

  always #5 clk = ~clk;

  logic [XW-1:0] mem [1024];
  int            checks = 0, passes = 0;
  int            cyc = 0, ready_mode = 0;
  int            last_acc_cyc = 0, done_rise_cyc = -1, rd_cnt = 0, epoch = 0;
  int            lines_model = 0;
  logic [63:0]   got_addr [$];
  logic [511:0]  got_data [$];

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [XW-1:0] rand_word();
    logic [XW-1:0] w;
    for (int i = 0; i < XW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // BRAM with two-cycle read latency, host-side ready driver and beat monitor.
  initial begin
    logic          s0_en, s1_en, prev_stall, prev_done;
    logic [AW-1:0] s0_addr, s1_addr;
    logic [63:0]   st_addr;
    logic [511:0]  st_data;
    s0_en = 0; s1_en = 0; s0_addr = '0; s1_addr = '0;
    prev_stall = 0; prev_done = 0; st_addr = '0; st_data = '0;
    x_rd_data = '0; ready = 0;
    forever begin
      @(negedge clk);
      cyc++;
      x_rd_data = s1_en ? mem[s1_addr] : rand_word();
      s1_en = s0_en; s1_addr = s0_addr;
      s0_en = x_rd_en; s0_addr = x_rd_addr;
      if (x_rd_en) rd_cnt++;
      if (!rst_n) begin
        prev_stall = 0; prev_done = 0; ready = 0; lines_model = 0;
      end else begin
        if (done && !prev_done) done_rise_cyc = cyc;
        prev_done = done;
        case (ready_mode)
          0:       ready = 1'b1;
          1:       ready = (cyc % 3 == 0);
          default: ready = 1'($urandom);
        endcase
        if (prev_stall) begin
          check("stall_addr", {valid, wr_addr}, {1'b1, st_addr});
          check("stall_data", wr_data, st_data);
        end
        if (valid && ready) begin
          got_addr.push_back(wr_addr);
          got_data.push_back(wr_data);
          last_acc_cyc = cyc;
          lines_model++;
        end
        prev_stall = valid && !ready;
        st_addr = wr_addr;
        st_data = wr_data;
      end
    end
  end

  task automatic run_xfer(input logic [31:0] dim, input logic [63:0] base, input int mode,
                          input bit early_drop);
    longint      n, l;
    int          en_cyc, waited;
    bit          hold_ok;
    logic [63:0] exp_addr;
    logic [XW-1:0] hi;
    n = (longint'(dim) + 127) / 128;
    l = (n + 1) / 2;
    got_addr.delete();
    got_data.delete();
    ready_mode = mode;
    dimension = dim;
    addr_model = base;
    repeat (2) @(negedge clk);
    #1;
    rd_cnt = 0;
    done_rise_cyc = -1;
    en = 1'b1;
    en_cyc = cyc;
    if (early_drop) begin
      @(negedge clk); #1;
      en = 1'b0;
    end
    waited = 0;
    while (!done && waited < 3000) begin
      @(negedge clk); #1;
      waited++;
    end
    check("done_seen", 512'(done), 512'd1);
    check("beat_count", 512'(got_addr.size()), 512'(l));
    check("read_count", 512'(rd_cnt), 512'(n));
    for (int k = 0; k < l && k < got_addr.size(); k++) begin
      exp_addr = base + 64'(k) * 64;
`ifdef SGD_X_HOST_WR_EPOCH_OFFSET_EN
      exp_addr = exp_addr + 64'(epoch) * 64'(l) * 64;
`endif
      hi = (2 * k + 1 < n) ? mem[2*k+1] : '0;
      check($sformatf("beat%0d_addr", k), 512'(got_addr[k]), 512'(exp_addr));
      check($sformatf("beat%0d_data", k), got_data[k], {hi, mem[2*k]});
    end
    if (n > 0) check("done_latency", 512'(done_rise_cyc), 512'(last_acc_cyc + 1));
    else if (!early_drop) check("done_latency_n0", 512'(done_rise_cyc), 512'(en_cyc + 2));
    if (!early_drop) begin
      hold_ok = 1;
      repeat (3) begin
        @(negedge clk); #1;
        hold_ok = hold_ok && done;
      end
      check("done_hold", 512'(hold_ok), 512'd1);
      en = 1'b0;
    end
    @(negedge clk); #1;
    check("done_clear", 512'(done), 512'd0);
    check("lines_count", 512'(lines), 512'(lines_model));
    epoch++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int       n;
    int       waited;
    logic [63:0] base;
    for (int i = 0; i < 1024; i++) mem[i] = rand_word();
    rst_n = 0; started = 0; en = 0; dimension = '0; addr_model = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_done", 512'(done), 512'd0);
    check("rst_rd", {x_rd_en, x_rd_addr}, '0);
    check("rst_valid", 512'(valid), 512'd0);
    check("rst_addr", 512'(wr_addr), 512'd0);
    check("rst_data", wr_data, '0);
    check("rst_lines", 512'(lines), 512'd0);
    rst_n = 1;
    started = 1;
    epoch = 0;

    run_xfer(32'd1024, 64'h1000, 0, 0);
    run_xfer(32'd640,  64'h2000, 0, 0);
    run_xfer(32'd2048, 64'h3000, 1, 0);
    run_xfer(32'd0,    64'h4000, 0, 0);
    run_xfer(32'd700,  64'h5000, 2, 1);

    @(negedge clk); #1 started = 0;
    @(negedge clk); #1 started = 1;
    epoch = 0;
    run_xfer(32'd1024, 64'h8000, 0, 0);
    run_xfer(32'd1024, 64'h8000, 2, 0);

    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(0, 24);
      base = {$urandom, $urandom} & ~64'h3f;
      run_xfer((n == 0) ? 32'd0 : 32'((n - 1) * 128 + $urandom_range(1, 128)), base,
               $urandom_range(0, 2), (i == 2));
    end

    ready_mode = 1;
    dimension = 32'd2048;
    addr_model = 64'hA000;
    repeat (2) @(negedge clk);
    #1;
    rd_cnt = 0;
    en = 1;
    waited = 0;
    while (rd_cnt < 5 && waited < 200) begin
      @(negedge clk); #1;
      waited++;
    end
    check("pre_reset_reads", 512'(rd_cnt >= 5), 512'd1);
    rst_n = 0;
    en = 0;
    @(negedge clk); #1;
    check("reset_valid", 512'(valid), 512'd0);
    check("reset_rd_en", 512'(x_rd_en), 512'd0);
    check("reset_done", 512'(done), 512'd0);
    rst_n = 1;
    epoch = 0;
    run_xfer(32'd2048, 64'hA000, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
